// File: rtl/tour_cmd_sched.sv
// Host-side Knight command scheduler: queues 16-bit commands and issues each to
// RemoteComm only after the previous one drew 0xA5, with timeout/retry and error reporting.
module tour_cmd_sched #(
  parameter int DEPTH        = 8,
  parameter int RESP_TIMEOUT = 4000000,
  parameter int MAX_RETRY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_cmd,
  input  logic [15:0] cmd_in,
  output logic        full,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [4:0]  acked
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST  = CW'(RESP_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [1:0] CODE_TMO   = 2'b01;
  localparam logic [1:0] CODE_NAK   = 2'b10;
  localparam logic [1:0] CODE_ABORT = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [15:0]     cmd_q;
  logic [RW-1:0]   retry_q;
  logic [CW-1:0]   tmo_cnt_q;
  logic            err_q, done_q, abort_q;
  logic [1:0]      err_code_q;
  logic [4:0]      acked_q;

  logic fifo_empty, fifo_full, pop, flush, push;
  logic abort_now, is_ack, tmo_hit;
  logic ev_clear, ev_ack, ev_retry, ev_err, done_d;
  logic [1:0] ev_code;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = (state_q == LOAD);
  assign flush      = (state_q == FLUSH);
  assign push       = wr_cmd && !flush && (!fifo_full || pop);

  assign abort_now  = abort_q || abort;
  assign is_ack     = (resp == 8'hA5);
  assign tmo_hit    = (tmo_cnt_q == TMO_LAST) && !resp_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (flush)    rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start && !fifo_empty) state_d = LOAD;
      LOAD:      state_d = ev_err ? FLUSH : SEND;
      SEND:      state_d = WAIT_SENT;
      WAIT_SENT: if (cmd_sent) state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (ev_err)        state_d = FLUSH;
        else if (ev_retry) state_d = SEND;
        else if (ev_ack)   state_d = done_d ? IDLE : LOAD;
      end
      FLUSH:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / event decode; a response in the timeout cycle takes priority.
  always_comb begin
    send_cmd = (state_q == SEND);
    busy     = (state_q != IDLE);
    ev_clear = 1'b0;
    ev_ack   = 1'b0;
    ev_retry = 1'b0;
    ev_err   = 1'b0;
    ev_code  = 2'b00;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        ev_clear = 1'b1;
        done_d   = fifo_empty;
      end
      LOAD: if (abort_now) begin
        ev_err  = 1'b1;
        ev_code = CODE_ABORT;
      end
      WAIT_RESP: begin
        if (resp_rdy) begin
          if (is_ack) begin
            ev_ack = 1'b1;
            if (fifo_empty) begin
              done_d = 1'b1;
            end else if (abort_now) begin
              ev_err  = 1'b1;
              ev_code = CODE_ABORT;
            end
          end else begin
            ev_err  = 1'b1;
            ev_code = CODE_NAK;
          end
        end else if (tmo_hit) begin
          if (abort_now) begin
            ev_err  = 1'b1;
            ev_code = CODE_ABORT;
          end else if (retry_q < RETRY_MAX) begin
            ev_retry = 1'b1;
          end else begin
            ev_err  = 1'b1;
            ev_code = CODE_TMO;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= 16'h0000;
      retry_q    <= '0;
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      acked_q    <= 5'd0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      if (pop) begin
        cmd_q   <= mem_q[rd_ptr_q[AW-1:0]];
        retry_q <= '0;
      end else if (ev_retry) begin
        retry_q <= retry_q + 1'b1;
      end
      if (state_q == WAIT_SENT && cmd_sent) tmo_cnt_q <= '0;
      else if (state_q == WAIT_RESP && tmo_cnt_q != TMO_LAST) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (ev_clear) begin
        err_q      <= 1'b0;
        err_code_q <= 2'b00;
        acked_q    <= 5'd0;
      end else begin
        if (ev_err) begin
          err_q      <= 1'b1;
          err_code_q <= ev_code;
        end
        if (ev_ack && acked_q != 5'd31) acked_q <= acked_q + 5'd1;
      end
      // A pending abort is forgotten once the FSM is back in IDLE.
      if (state_q != IDLE && state_d == IDLE) abort_q <= 1'b0;
      else if (abort && state_q != IDLE)      abort_q <= 1'b1;
    end
  end

  assign full     = fifo_full;
  assign cmd      = cmd_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign acked    = acked_q;

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Scoreboard bench for tour_cmd_sched with a behavioural RemoteComm responder.
module tb_tour_cmd_sched;
  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int MAXR  = 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_cmd = 1'b0, start = 1'b0, abort = 1'b0;
  logic        cmd_sent = 1'b0, resp_rdy = 1'b0;
  logic [15:0] cmd_in = 16'h0;
  logic [7:0]  resp = 8'h0;
  logic        full, send_cmd, busy, done, err;
  logic [15:0] cmd;
  logic [1:0]  err_code;
  logic [4:0]  acked;

  tour_cmd_sched #(.DEPTH(DEPTH), .RESP_TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .wr_cmd(wr_cmd), .cmd_in(cmd_in), .full(full),
    .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .acked(acked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_q[$];
  int plan[$];
  int send_cycs[$], sent_cycs[$], resp_cycs[$];
  int done_cnt = 0, done_cyc = 0, resp_delay = 2, st_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Monitor: every launch is checked against the head of the expected queue.
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (send_cmd === 1'b1) begin
        send_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_send: got cmd 0x%0h, expected no launch", cmd);
        end else begin
          e = exp_q.pop_front();
          chk("send_cmd_value", {16'h0, cmd}, {16'h0, e});
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // RemoteComm model: frame takes 3 cycles, response follows after resp_delay.
  initial begin : remote
    int r;
    forever begin
      @(negedge clk);
      if (send_cmd === 1'b1 && !rst) begin
        repeat (3) @(negedge clk);
        cmd_sent = 1'b1;
        sent_cycs.push_back(cyc);
        @(negedge clk);
        cmd_sent = 1'b0;
        repeat (resp_delay) @(negedge clk);
        if (plan.size() > 0) begin
          r = plan.pop_front();
          resp = r[7:0];
          resp_rdy = 1'b1;
          resp_cycs.push_back(cyc);
          @(negedge clk);
          resp_rdy = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [15:0] v, input bit will_send);
    @(negedge clk);
    wr_cmd = 1'b1;
    cmd_in = v;
    @(negedge clk);
    wr_cmd = 1'b0;
    if (will_send) exp_q.push_back(v);
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'h0, busy}, 0);
  endtask

  task automatic new_test;
    exp_q.delete(); plan.delete();
    send_cycs.delete(); sent_cycs.delete(); resp_cycs.delete();
    done_cnt = 0;
  endtask

  task automatic end_test(input string nm);
    chk({nm, "_pending_sends"}, exp_q.size(), 0);
  endtask

  // An empty FIFO answers start with a done pulse and no launch.
  task automatic check_flushed(input string nm);
    int d0;
    d0 = done_cnt;
    pulse_start;
    repeat (3) @(negedge clk);
    chk({nm, "_flushed_done"}, done_cnt - d0, 1);
    chk({nm, "_flushed_busy"}, {31'h0, busy}, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int k;
    repeat (3) @(negedge clk);
    chk("rst_cmd", {16'h0, cmd}, 0);
    chk("rst_send_cmd", {31'h0, send_cmd}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_err_code", {30'h0, err_code}, 0);
    chk("rst_acked", {27'h0, acked}, 0);
    chk("rst_full", {31'h0, full}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two commands, both acknowledged
    new_test;
    push(16'h2000, 1); push(16'h47F1, 1);
    plan.push_back(8'hA5); plan.push_back(8'hA5);
    pulse_start;
    wait_idle("t1_idle");
    repeat (4) @(negedge clk);
    chk("t1_sends", send_cycs.size(), 2);
    chk("t1_acked", {27'h0, acked}, 2);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", {31'h0, err}, 0);
    chk("t1_err_code", {30'h0, err_code}, 0);
    chk("t1_start_to_send", (send_cycs.size() > 0) ? send_cycs[0] - st_cyc : -1, 2);
    chk("t1_ack_to_send", (send_cycs.size() > 1 && resp_cycs.size() > 0) ? send_cycs[1] - resp_cycs[0] : -1, 2);
    chk("t1_done_latency", (resp_cycs.size() > 1) ? done_cyc - resp_cycs[1] : -1, 1);
    end_test("t1");

    // Response withheld: one retry, then timeout error
    new_test;
    push(16'h47F1, 1);
    exp_q.push_back(16'h47F1);
    pulse_start;
    wait_idle("t2_idle");
    repeat (4) @(negedge clk);
    chk("t2_sends", send_cycs.size(), 2);
    chk("t2_retry_gap", (send_cycs.size() > 1 && sent_cycs.size() > 0) ? send_cycs[1] - sent_cycs[0] : -1, TMO + 1);
    chk("t2_err", {31'h0, err}, 1);
    chk("t2_err_code", {30'h0, err_code}, 1);
    chk("t2_done_cnt", done_cnt, 0);
    chk("t2_acked", {27'h0, acked}, 0);
    end_test("t2");
    check_flushed("t2");

    // Second of three draws a NAK
    new_test;
    push(16'h47F1, 1); push(16'h4401, 1); push(16'h5000, 0);
    plan.push_back(8'hA5); plan.push_back(8'h5A);
    pulse_start;
    wait_idle("t3_idle");
    repeat (6) @(negedge clk);
    chk("t3_sends", send_cycs.size(), 2);
    chk("t3_err", {31'h0, err}, 1);
    chk("t3_err_code", {30'h0, err_code}, 2);
    chk("t3_acked", {27'h0, acked}, 1);
    chk("t3_done_cnt", done_cnt, 0);
    end_test("t3");
    check_flushed("t3");

    // Fill to DEPTH, overflow push dropped, drain across pointer wrap
    new_test;
    for (int i = 0; i < DEPTH; i++) push(16'h1000 + 16'(i), 1);
    chk("t4_full", {31'h0, full}, 1);
    push(16'hDEAD, 0);
    chk("t4_full_after_drop", {31'h0, full}, 1);
    for (int i = 0; i < DEPTH; i++) plan.push_back(8'hA5);
    pulse_start;
    wait_idle("t4_idle");
    repeat (4) @(negedge clk);
    chk("t4_sends", send_cycs.size(), DEPTH);
    chk("t4_acked", {27'h0, acked}, DEPTH);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_err", {31'h0, err}, 0);
    chk("t4_full_after", {31'h0, full}, 0);
    end_test("t4");

    // Abort during WAIT_SENT of the first of three
    new_test;
    push(16'h2000, 1); push(16'h47F1, 0); push(16'h4401, 0);
    plan.push_back(8'hA5);
    pulse_start;
    k = 0;
    while (send_cmd !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("t5_idle");
    repeat (6) @(negedge clk);
    chk("t5_sends", send_cycs.size(), 1);
    chk("t5_frame_completed", sent_cycs.size(), 1);
    chk("t5_err", {31'h0, err}, 1);
    chk("t5_err_code", {30'h0, err_code}, 3);
    chk("t5_acked", {27'h0, acked}, 1);
    chk("t5_done_cnt", done_cnt, 0);
    end_test("t5");
    check_flushed("t5");

    // Reset in WAIT_RESP, then a stale response arrives
    new_test;
    resp_delay = 8;
    push(16'h47F1, 1);
    plan.push_back(8'hA5);
    pulse_start;
    k = 0;
    while (cmd_sent !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_resp_delivered", resp_cycs.size(), 1);
    chk("t6_cmd", {16'h0, cmd}, 0);
    chk("t6_send_cmd", {31'h0, send_cmd}, 0);
    chk("t6_busy", {31'h0, busy}, 0);
    chk("t6_done", {31'h0, done}, 0);
    chk("t6_err", {31'h0, err}, 0);
    chk("t6_err_code", {30'h0, err_code}, 0);
    chk("t6_acked", {27'h0, acked}, 0);
    chk("t6_full", {31'h0, full}, 0);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_sends", send_cycs.size(), 1);
    end_test("t6");
    resp_delay = 2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tour_cmd_sched.md
# tour_cmd_sched

Host-side command scheduler that sequences a queued list of 16-bit Knight commands (gyro calibrate, moves, tour start) through the RemoteComm UART command datapath. It sits between test or host logic and RemoteComm. It buffers commands in a FIFO, and issues each one only after the previous one has drawn a positive acknowledge (0xA5). Per-command timeouts, bounded retries and error reporting are handled internally, so benches and host logic do not hand-sequence send_cmd, cmd_sent and resp_rdy.

## Interface
- DEPTH, 8: command FIFO entries; power of two, 2 to 16.
- RESP_TIMEOUT, 4000000: clocks allowed from cmd_sent to resp_rdy before a timeout.
- MAX_RETRY, 1: re-sends allowed per command after a timeout. A NAK is never retried.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_cmd  in  1  push cmd_in into the FIFO; ignored while full
- cmd_in  in  16  command to queue
- full  out  1  FIFO holds DEPTH entries
- start  in  1  begin draining the FIFO; honoured only in IDLE
- abort  in  1  stop after the current handshake; flush the FIFO
- cmd  out  16  command presented to RemoteComm
- send_cmd  out  1  one-cycle launch strobe to RemoteComm
- cmd_sent  in  1  RemoteComm finished transmitting cmd
- resp_rdy  in  1  RemoteComm received a response byte
- resp  in  8  response byte; valid while resp_rdy is high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the FIFO drains with no error
- err  out  1  sticky error flag; cleared by start or rst
- err_code  out  2  00 none, 01 timeout after retries, 10 NAK (resp not 0xA5), 11 aborted
- acked  out  5  count of positively acknowledged commands since the last start; saturates at 31

## Operation
- States: IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, FLUSH.
- IDLE, start high:
  - FIFO empty: pulse done, stay in IDLE.
  - Otherwise: clear err, err_code and acked, then go to LOAD.
- LOAD: pop the FIFO head into the cmd register; retry count = 0; go to SEND.
- SEND: assert send_cmd for exactly one cycle; go to WAIT_SENT.
- WAIT_SENT: wait for cmd_sent; then clear the timeout counter and go to WAIT_RESP.
- WAIT_RESP, resp_rdy high:
  - resp == 0xA5: increment acked. FIFO non-empty goes to LOAD. FIFO empty pulses done and goes to IDLE.
  - Any other byte: err = 1, err_code = 10, go to FLUSH.
- WAIT_RESP timeout: the counter reaches RESP_TIMEOUT-1 with no resp_rdy.
  - Retry count < MAX_RETRY: increment it and go to SEND with the same cmd.
  - Otherwise: err = 1, err_code = 01, go to FLUSH.
- FLUSH: empty the FIFO in one cycle; go to IDLE. done is not pulsed.
- abort:
  - Sampled in any busy state and latched.
  - It takes effect at the next point the FSM would enter LOAD or SEND, or immediately from WAIT_RESP on timeout.
  - Result: err = 1, err_code = 11, go to FLUSH.
  - The current RemoteComm transaction is never cut mid-frame.
- FIFO: an independent circular buffer with wrapping pointers.
  - wr_cmd is accepted in any state, including during execution, so queue extension is legal.
  - Simultaneous push and pop when full: the pop frees a slot and the push is accepted.
  - A push while full with no pop is dropped; contents are unchanged.
- cmd holds its value from LOAD until the next LOAD, so it stays stable across the whole send and retry period.
- resp_rdy outside WAIT_RESP is ignored. A stale response must not advance the queue.
- acked saturates at 31 and does not wrap.

## Timing
- Reset values:
  - State IDLE; FIFO empty; full = 0.
  - cmd = 16'h0000; send_cmd = 0; busy = 0; done = 0.
  - err = 0; err_code = 00; acked = 0.
- start to the first send_cmd: 2 cycles (IDLE→LOAD→SEND; send_cmd high in the SEND cycle).
- Positive ack to the next send_cmd: 2 cycles (WAIT_RESP→LOAD→SEND).
- done pulses in the cycle after the final resp_rdy is sampled. busy falls in that same cycle.
- Timeout boundary: a resp_rdy arriving in the same cycle the counter hits RESP_TIMEOUT-1 wins; it is treated as a response.
- A reset mid-operation returns every register to its reset value immediately. RemoteComm may still complete its frame; the resulting resp_rdy is ignored in IDLE.

## Test plan
- Queue 16'h2000 (cal gyro) and 16'h47F1 (move south 1), then start; RemoteComm returns 0xA5 twice. Required: send_cmd pulses twice, cmd values in that order, acked = 2, one done pulse, err = 0.
- Queue 16'h47F1, start, withhold resp_rdy, with MAX_RETRY = 1 and RESP_TIMEOUT = 100. Required: a second send_cmd about 100 clocks after the first cmd_sent, then err = 1, err_code = 01, FIFO empty, no done pulse.
- Queue 3 commands; the second draws resp = 0x5A. Required: err_code = 10, acked = 1, the third command is never sent, FIFO flushed.
- Fill the FIFO to DEPTH, push once more, then drain. Required: full = 1 and the extra push dropped; exactly DEPTH commands sent, in order across pointer wrap.
- Assert abort during WAIT_SENT of the first of 3 commands. Required: the frame completes, no further send_cmd, err_code = 11, busy low after FLUSH.
- Assert rst mid-WAIT_RESP, then deliver resp_rdy. Required: all outputs at reset values, acked stays 0, the state remains IDLE.
